seq_generator: RTL
==================

SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 8'hA5, meaning the LFSR load value used when START=0 in MODE 3.
REQ-002 SHALL have port SYSCLK  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port RST_B  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port CMD_VALID  input  1  command request.
REQ-005 SHALL have port CMD_READY  output  1  command accept; high only in IDLE.
REQ-006 SHALL have port MODE  input  2  pattern select, sampled at accept: 0 = +1 step, 1 = -1 step, 2 = constant, 3 = pseudo-random.
REQ-007 SHALL have port START  input  4  first nibble (MODE 0-2), or LFSR seed low nibble (MODE 3), sampled at accept.
REQ-008 SHALL have port LEN  input  4  nibble count, sampled at accept; 0 means 16.
REQ-009 SHALL have port GAP  input  2  idle cycles inserted between consecutive nibbles, sampled at accept.
REQ-010 SHALL have port ABORT  input  1  synchronous cancel of the current burst.
REQ-011 SHALL have port OUT_VALID  output  1  nibble strobe; drives the detector IN_VALID.
REQ-012 SHALL have port DATA_OUT  output  4  nibble; drives the detector DATA_IN.
REQ-013 SHALL have port BUSY  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse after a burst completes normally.

Function
REQ-015 SHALL implement FSM states IDLE, EMIT, WAIT, FIN.
REQ-016 SHALL accept a command when CMD_VALID && CMD_READY at a rising edge, latch MODE/START/LEN/GAP, and enter EMIT.
REQ-017 SHALL register all outputs; first nibble OUT_VALID=1 in the cycle after accept (latency 1).
REQ-018 SHALL in EMIT drive OUT_VALID=1 for exactly one cycle with the current nibble.
REQ-019 SHALL drive DATA_OUT=4'h0 whenever OUT_VALID=0.
REQ-020 SHALL after a nibble, if nibbles remain: go to WAIT for GAP cycles (OUT_VALID=0), then EMIT; GAP=0 means back-to-back EMIT.
REQ-021 SHALL compute nibble n+1 as: MODE 0 = n+1 mod 16 (4'hF -> 4'h0), MODE 1 = n-1 mod 16 (4'h0 -> 4'hF), MODE 2 = n.
REQ-022 SHALL in MODE 3 use an 8-bit Fibonacci LFSR with taps 8,6,5,4 that shifts once per emitted nibble and outputs LFSR[3:0]; seed = {4'h5, START} if START!=0, else LFSR_SEED.
REQ-023 SHALL never load the LFSR with all zeros.
REQ-024 SHALL count emitted nibbles with a 5-bit counter; after the LEN-th nibble (16 for LEN=0), go to FIN with no trailing gap.
REQ-025 SHALL in FIN assert DONE=1 for one cycle, then return to IDLE; CMD_READY=1 again the cycle after FIN.
REQ-026 SHALL give ABORT priority over all transitions: in any non-IDLE state, the next state is IDLE, OUT_VALID=0, DATA_OUT=0, and DONE is not asserted.
REQ-027 SHALL ignore ABORT in IDLE; CMD_VALID and ABORT high together in IDLE accepts the command.
REQ-028 SHALL ignore CMD_VALID while BUSY, with no queuing.
REQ-029 SHALL ignore changes on MODE/START/LEN/GAP after accept.

Reset
REQ-030 SHALL on RST_B low immediately force IDLE, with outputs OUT_VALID=0, DATA_OUT=0, DONE=0, BUSY=0, CMD_READY=1, counter=0, LFSR=LFSR_SEED.
REQ-031 SHALL on reset mid-burst drop the burst silently; the first command after release starts a fresh burst.

Verification
REQ-032 SHALL pass: MODE=0, START=4'hE, LEN=4, GAP=0 -> DATA_OUT E,F,0,1 on 4 consecutive cycles starting 1 cycle after accept; DONE on cycle 6.
REQ-033 SHALL pass: MODE=1, START=4'h1, LEN=3, GAP=2 -> 1,_,_,0,_,_,F with OUT_VALID=1 only on the nibble cycles; DONE the cycle after F.
REQ-034 SHALL pass: MODE=2, START=4'h7, LEN=0 -> sixteen consecutive 7s, then DONE; CMD_VALID held high during the burst is not accepted.
REQ-035 SHALL pass: MODE=3, START=0, LEN=5 -> 5 nibbles matching the reference LFSR model from 8'hA5; a repeat run gives an identical sequence.
REQ-036 SHALL pass: ABORT asserted on the 3rd nibble cycle of a LEN=8 burst -> OUT_VALID=0 next cycle, no DONE, CMD_READY=1.
REQ-037 SHALL pass: loopback into seq_detector_fjl with MODE 0/1/2 and LEN=3 -> the detector asserts OUT_VALID with DATA_OUT equal to the third nibble.

Source files
------------

// File: rtl/seq_generator.sv
// Nibble burst generator: accepts a command, then emits LEN nibbles (count-up,
// count-down, constant or LFSR) with GAP idle cycles between them.
module seq_generator #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       SYSCLK,
  input  logic       RST_B,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] MODE,
  input  logic [3:0] START,
  input  logic [3:0] LEN,
  input  logic [1:0] GAP,
  input  logic       ABORT,
  output logic       OUT_VALID,
  output logic [3:0] DATA_OUT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {IDLE, EMIT, WAIT, FIN} state_t;

  // An all-zero LFSR would lock up, so a zero seed parameter is replaced.
  localparam logic [7:0] SAFE_SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_t      state_q;
  logic [1:0]  mode_q;
  logic [1:0]  gap_q;
  logic [1:0]  gcnt_q;
  logic [4:0]  len_q;
  logic [4:0]  cnt_q;
  logic [3:0]  cur_q;
  logic [7:0]  lfsr_q;
  logic        out_valid_q;
  logic [3:0]  data_out_q;
  logic        busy_q;
  logic        done_q;
  logic        ready_q;

  logic [7:0]  lfsr_shift_d;
  logic [7:0]  seed_d;
  logic [3:0]  first_d;
  logic [3:0]  nib_next_d;
  logic [4:0]  cnt_inc_d;
  logic        last_d;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    lfsr_shift_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    seed_d       = (START != 4'h0) ? {4'h5, START} : SAFE_SEED;
    first_d      = (MODE == 2'd3) ? seed_d[3:0] : START;
    cnt_inc_d    = cnt_q + 5'd1;
    last_d       = (cnt_inc_d == len_q);
    nib_next_d   = cur_q;
    case (mode_q)
      2'd0:    nib_next_d = cur_q + 4'd1;
      2'd1:    nib_next_d = cur_q - 4'd1;
      2'd2:    nib_next_d = cur_q;
      default: nib_next_d = lfsr_shift_d[3:0];
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q     <= IDLE;
      mode_q      <= 2'd0;
      gap_q       <= 2'd0;
      gcnt_q      <= 2'd0;
      len_q       <= 5'd0;
      cnt_q       <= 5'd0;
      cur_q       <= 4'h0;
      lfsr_q      <= LFSR_SEED;
      out_valid_q <= 1'b0;
      data_out_q  <= 4'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else if (state_q != IDLE && ABORT) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      data_out_q  <= 4'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (CMD_VALID && ready_q) begin
            state_q     <= EMIT;
            mode_q      <= MODE;
            gap_q       <= GAP;
            len_q       <= (LEN == 4'h0) ? 5'd16 : {1'b0, LEN};
            cnt_q       <= 5'd0;
            lfsr_q      <= seed_d;
            cur_q       <= first_d;
            out_valid_q <= 1'b1;
            data_out_q  <= first_d;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
          end
        end
        EMIT: begin
          cnt_q <= cnt_inc_d;
          if (last_d) begin
            state_q     <= FIN;
            out_valid_q <= 1'b0;
            data_out_q  <= 4'h0;
            done_q      <= 1'b1;
          end else begin
            // cur_q always holds the nibble to emit next, even across a gap.
            cur_q <= nib_next_d;
            if (mode_q == 2'd3) lfsr_q <= lfsr_shift_d;
            if (gap_q == 2'd0) begin
              out_valid_q <= 1'b1;
              data_out_q  <= nib_next_d;
            end else begin
              state_q     <= WAIT;
              gcnt_q      <= gap_q;
              out_valid_q <= 1'b0;
              data_out_q  <= 4'h0;
            end
          end
        end
        WAIT: begin
          if (gcnt_q == 2'd1) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
            data_out_q  <= cur_q;
          end else begin
            gcnt_q <= gcnt_q - 2'd1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign CMD_READY = ready_q;
  assign OUT_VALID = out_valid_q;
  assign DATA_OUT  = data_out_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule
